// File: rtl/spi_engine_arbiter.sv
// spi_engine_arbiter: lets two command sources (s0, s1) share one SPI engine
// execution stream (cmd/sdo/sdi/sync). A source owns the engine from its first
// command until the engine returns a sync word. While it owns the engine, the
// source's streams are muxed to the engine and the engine's streams are
// demuxed back to it.
//
// Build option: define SPI_ENGINE_ARBITER_RR_EN to replace fixed s0 priority
// with round-robin arbitration on simultaneous requests.
module spi_engine_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  spi_clk,
  input  logic                  spi_reset,

  input  logic                  s0_cmd_valid,
  output logic                  s0_cmd_ready,
  input  logic [15:0]           s0_cmd_data,
  input  logic                  s0_sdo_valid,
  output logic                  s0_sdo_ready,
  input  logic [DATA_WIDTH-1:0] s0_sdo_data,
  output logic                  s0_sdi_valid,
  input  logic                  s0_sdi_ready,
  output logic [DATA_WIDTH-1:0] s0_sdi_data,
  output logic                  s0_sync_valid,
  input  logic                  s0_sync_ready,
  output logic [7:0]            s0_sync_data,

  input  logic                  s1_cmd_valid,
  output logic                  s1_cmd_ready,
  input  logic [15:0]           s1_cmd_data,
  input  logic                  s1_sdo_valid,
  output logic                  s1_sdo_ready,
  input  logic [DATA_WIDTH-1:0] s1_sdo_data,
  output logic                  s1_sdi_valid,
  input  logic                  s1_sdi_ready,
  output logic [DATA_WIDTH-1:0] s1_sdi_data,
  output logic                  s1_sync_valid,
  input  logic                  s1_sync_ready,
  output logic [7:0]            s1_sync_data,

  output logic                  m_cmd_valid,
  input  logic                  m_cmd_ready,
  output logic [15:0]           m_cmd_data,
  output logic                  m_sdo_valid,
  input  logic                  m_sdo_ready,
  output logic [DATA_WIDTH-1:0] m_sdo_data,
  input  logic                  m_sdi_valid,
  output logic                  m_sdi_ready,
  input  logic [DATA_WIDTH-1:0] m_sdi_data,
  input  logic                  m_sync_valid,
  output logic                  m_sync_ready,
  input  logic [7:0]            m_sync_data,

  output logic [1:0]            grant,
  output logic                  busy
);

  // The state encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   tie_to_s0;

`ifdef SPI_ENGINE_ARBITER_RR_EN
  // Round-robin pointer: 1 when s0 held the most recent grant. The reset
  // value 0 treats s1 as the last owner, so s0 wins the first tie.
  logic last_s0_q, last_s0_d;

  // On a simultaneous request the source that did not own last wins.
  always_comb begin
    tie_to_s0 = ~last_s0_q;
  end

  // Pointer follows the winner on every entry into an ownership state.
  always_comb begin
    last_s0_d = last_s0_q;
    if (state_q == IDLE && state_d == OWN0) last_s0_d = 1'b1;
    if (state_q == IDLE && state_d == OWN1) last_s0_d = 1'b0;
  end

  // Pointer register.
  always_ff @(posedge spi_clk) begin
    if (spi_reset) last_s0_q <= 1'b0;
    else           last_s0_q <= last_s0_d;
  end
`else
  // Fixed priority: s0 wins every simultaneous request.
  always_comb begin
    tie_to_s0 = 1'b1;
  end
`endif

  // State register; reset abandons any in-flight transfer.
  always_ff @(posedge spi_clk) begin
    if (spi_reset) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next state: arbitrate from IDLE, release on a completed sync handshake.
  // The release always passes through IDLE, giving one bubble cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (s0_cmd_valid && s1_cmd_valid) state_d = tie_to_s0 ? OWN0 : OWN1;
        else if (s0_cmd_valid)            state_d = OWN0;
        else if (s1_cmd_valid)            state_d = OWN1;
      end
      OWN0, OWN1: begin
        if (m_sync_valid && m_sync_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Stream mux/demux gated by the registered grant. Valids only ever come
  // from the same stream's valid, never from its ready.
  always_comb begin
    m_cmd_valid   = 1'b0;
    m_sdo_valid   = 1'b0;
    m_sdi_ready   = 1'b0;
    m_sync_ready  = 1'b0;
    m_cmd_data    = s0_cmd_data;
    m_sdo_data    = s0_sdo_data;
    s0_cmd_ready  = 1'b0;
    s0_sdo_ready  = 1'b0;
    s0_sdi_valid  = 1'b0;
    s0_sync_valid = 1'b0;
    s1_cmd_ready  = 1'b0;
    s1_sdo_ready  = 1'b0;
    s1_sdi_valid  = 1'b0;
    s1_sync_valid = 1'b0;
    case (state_q)
      OWN0: begin
        m_cmd_valid   = s0_cmd_valid;
        s0_cmd_ready  = m_cmd_ready;
        m_sdo_valid   = s0_sdo_valid;
        s0_sdo_ready  = m_sdo_ready;
        s0_sdi_valid  = m_sdi_valid;
        m_sdi_ready   = s0_sdi_ready;
        s0_sync_valid = m_sync_valid;
        m_sync_ready  = s0_sync_ready;
      end
      OWN1: begin
        m_cmd_valid   = s1_cmd_valid;
        m_cmd_data    = s1_cmd_data;
        s1_cmd_ready  = m_cmd_ready;
        m_sdo_valid   = s1_sdo_valid;
        m_sdo_data    = s1_sdo_data;
        s1_sdo_ready  = m_sdo_ready;
        s1_sdi_valid  = m_sdi_valid;
        m_sdi_ready   = s1_sdi_ready;
        s1_sync_valid = m_sync_valid;
        m_sync_ready  = s1_sync_ready;
      end
      default: ;
    endcase
  end

  // Return-path data is broadcast; only the owner sees a valid.
  assign s0_sdi_data  = m_sdi_data;
  assign s1_sdi_data  = m_sdi_data;
  assign s0_sync_data = m_sync_data;
  assign s1_sync_data = m_sync_data;

  assign grant = state_q;
  assign busy  = |state_q;

endmodule

// File: tb/tb_spi_engine_arbiter.sv
// Directed bench for spi_engine_arbiter: a per-cycle vector table plus
// hand-written sequences for SDO/return data and repeated arbitration.
module tb_spi_engine_arbiter;

  localparam int DW = 8;

  logic          spi_clk = 1'b0;
  logic          spi_reset;
  logic          s0_cmd_valid, s0_cmd_ready;
  logic [15:0]   s0_cmd_data;
  logic          s0_sdo_valid, s0_sdo_ready;
  logic [DW-1:0] s0_sdo_data;
  logic          s0_sdi_valid, s0_sdi_ready;
  logic [DW-1:0] s0_sdi_data;
  logic          s0_sync_valid, s0_sync_ready;
  logic [7:0]    s0_sync_data;
  logic          s1_cmd_valid, s1_cmd_ready;
  logic [15:0]   s1_cmd_data;
  logic          s1_sdo_valid, s1_sdo_ready;
  logic [DW-1:0] s1_sdo_data;
  logic          s1_sdi_valid, s1_sdi_ready;
  logic [DW-1:0] s1_sdi_data;
  logic          s1_sync_valid, s1_sync_ready;
  logic [7:0]    s1_sync_data;
  logic          m_cmd_valid, m_cmd_ready;
  logic [15:0]   m_cmd_data;
  logic          m_sdo_valid, m_sdo_ready;
  logic [DW-1:0] m_sdo_data;
  logic          m_sdi_valid, m_sdi_ready;
  logic [DW-1:0] m_sdi_data;
  logic          m_sync_valid, m_sync_ready;
  logic [7:0]    m_sync_data;
  logic [1:0]    grant;
  logic          busy;

  always #5 spi_clk = ~spi_clk;

  spi_engine_arbiter #(.DATA_WIDTH(DW)) dut (
    .spi_clk(spi_clk), .spi_reset(spi_reset),
    .s0_cmd_valid(s0_cmd_valid), .s0_cmd_ready(s0_cmd_ready), .s0_cmd_data(s0_cmd_data),
    .s0_sdo_valid(s0_sdo_valid), .s0_sdo_ready(s0_sdo_ready), .s0_sdo_data(s0_sdo_data),
    .s0_sdi_valid(s0_sdi_valid), .s0_sdi_ready(s0_sdi_ready), .s0_sdi_data(s0_sdi_data),
    .s0_sync_valid(s0_sync_valid), .s0_sync_ready(s0_sync_ready), .s0_sync_data(s0_sync_data),
    .s1_cmd_valid(s1_cmd_valid), .s1_cmd_ready(s1_cmd_ready), .s1_cmd_data(s1_cmd_data),
    .s1_sdo_valid(s1_sdo_valid), .s1_sdo_ready(s1_sdo_ready), .s1_sdo_data(s1_sdo_data),
    .s1_sdi_valid(s1_sdi_valid), .s1_sdi_ready(s1_sdi_ready), .s1_sdi_data(s1_sdi_data),
    .s1_sync_valid(s1_sync_valid), .s1_sync_ready(s1_sync_ready), .s1_sync_data(s1_sync_data),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_data(m_cmd_data),
    .m_sdo_valid(m_sdo_valid), .m_sdo_ready(m_sdo_ready), .m_sdo_data(m_sdo_data),
    .m_sdi_valid(m_sdi_valid), .m_sdi_ready(m_sdi_ready), .m_sdi_data(m_sdi_data),
    .m_sync_valid(m_sync_valid), .m_sync_ready(m_sync_ready), .m_sync_data(m_sync_data),
    .grant(grant), .busy(busy)
  );

  typedef struct {
    logic        rst;
    logic        c0v;
    logic [15:0] c0d;
    logic        c1v;
    logic [15:0] c1d;
    logic        mcr;
    logic        iv;
    logic [7:0]  id;
    logic        sv;
    logic [7:0]  sd;
    logic        r0;
    logic        r1;
    logic [1:0]  g;
    logic        mcv;
    logic [15:0] mcd;
    logic        c0r, c1r, i0v, i1v, y0v, y1v, rdy;
  } vec_t;

  vec_t tbl[$];
  int n_chk  = 0;
  int n_pass = 0;

  function automatic vec_t mk(
    input logic rst, input logic c0v, input logic [15:0] c0d,
    input logic c1v, input logic [15:0] c1d, input logic mcr,
    input logic iv, input logic [7:0] id, input logic sv, input logic [7:0] sd,
    input logic r0, input logic r1,
    input logic [1:0] g, input logic mcv, input logic [15:0] mcd,
    input logic c0r, input logic c1r, input logic i0v, input logic i1v,
    input logic y0v, input logic y1v, input logic rdy);
    vec_t v;
    v.rst = rst; v.c0v = c0v; v.c0d = c0d; v.c1v = c1v; v.c1d = c1d; v.mcr = mcr;
    v.iv = iv; v.id = id; v.sv = sv; v.sd = sd; v.r0 = r0; v.r1 = r1;
    v.g = g; v.mcv = mcv; v.mcd = mcd; v.c0r = c0r; v.c1r = c1r;
    v.i0v = i0v; v.i1v = i1v; v.y0v = y0v; v.y1v = y1v; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", name, got, exp);
    else n_pass++;
  endtask

  task automatic apply(input vec_t v);
    spi_reset     = v.rst;
    s0_cmd_valid  = v.c0v;  s0_cmd_data = v.c0d;
    s1_cmd_valid  = v.c1v;  s1_cmd_data = v.c1d;
    m_cmd_ready   = v.mcr;
    m_sdi_valid   = v.iv;   m_sdi_data  = v.id;
    m_sync_valid  = v.sv;   m_sync_data = v.sd;
    s0_sdi_ready  = v.r0;   s0_sync_ready = v.r0;
    s1_sdi_ready  = v.r1;   s1_sync_ready = v.r1;
  endtask

  initial begin
    logic [31:0] got, expv;
    logic [1:0]  exp_g [6];

    spi_reset = 1'b1;
    s0_cmd_valid = 0; s0_cmd_data = 0; s0_sdo_valid = 0; s0_sdo_data = 8'hA5;
    s0_sdi_ready = 0; s0_sync_ready = 0;
    s1_cmd_valid = 0; s1_cmd_data = 0; s1_sdo_valid = 0; s1_sdo_data = 8'h5A;
    s1_sdi_ready = 0; s1_sync_ready = 0;
    m_cmd_ready = 0; m_sdo_ready = 0; m_sdi_valid = 0; m_sdi_data = 0;
    m_sync_valid = 0; m_sync_data = 0;
    repeat (2) @(posedge spi_clk);

    // rst c0v c0d c1v c1d mcr | iv id sv sd r0 r1 | g mcv mcd | c0r c1r i0v i1v y0v y1v rdy
    // Reset state and single-source transaction.
    tbl.push_back(mk(0,0,16'h0000,0,16'h0000,0, 0,8'h00,0,8'h00,0,0, 2'b00,0,16'h0000, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,16'h1001,0,16'h0000,1, 0,8'h00,0,8'h00,0,0, 2'b00,0,16'h0000, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,16'h1001,0,16'h0000,1, 0,8'h00,0,8'h00,0,0, 2'b01,1,16'h1001, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,16'h2002,0,16'h0000,1, 0,8'h00,0,8'h00,0,0, 2'b01,1,16'h2002, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,16'h2002,0,16'h0000,0, 1,8'h3C,0,8'h00,1,0, 2'b01,0,16'h2002, 0,0,1,0,0,0,1));
    tbl.push_back(mk(0,0,16'h2002,0,16'h0000,0, 0,8'h00,1,8'h07,1,0, 2'b01,0,16'h2002, 0,0,0,0,1,0,1));
    // Idle misuse by the engine: nothing accepted, nothing forwarded.
    tbl.push_back(mk(0,0,16'h0000,0,16'h0000,1, 1,8'hAA,1,8'h09,1,1, 2'b00,0,16'h0000, 0,0,0,0,0,0,0));
    // Reset mid-ownership after 2 accepted commands, then re-request.
    tbl.push_back(mk(0,1,16'h0101,0,16'h0000,1, 0,8'h00,0,8'h00,0,0, 2'b00,0,16'h0000, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,16'h0101,0,16'h0000,1, 0,8'h00,0,8'h00,0,0, 2'b01,1,16'h0101, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,16'h0202,0,16'h0000,1, 0,8'h00,0,8'h00,0,0, 2'b01,1,16'h0202, 1,0,0,0,0,0,0));
    tbl.push_back(mk(1,1,16'h0303,0,16'h0000,1, 0,8'h00,0,8'h00,0,0, 2'b01,1,16'h0303, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,16'h0303,0,16'h0000,1, 0,8'h00,0,8'h00,0,0, 2'b00,0,16'h0000, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,16'h0303,0,16'h0000,1, 0,8'h00,0,8'h00,0,0, 2'b01,1,16'h0303, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,16'h0303,0,16'h0000,0, 0,8'h00,1,8'h01,1,0, 2'b01,0,16'h0303, 0,0,0,0,1,0,1));
    tbl.push_back(mk(1,0,16'h0000,0,16'h0000,0, 0,8'h00,0,8'h00,0,0, 2'b00,0,16'h0000, 0,0,0,0,0,0,0));
    // Simultaneous request: s0 first (also the first tie in round-robin).
    tbl.push_back(mk(0,1,16'h0A01,1,16'h0B01,1, 0,8'h00,0,8'h00,0,0, 2'b00,0,16'h0000, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,16'h0A01,1,16'h0B01,1, 0,8'h00,0,8'h00,0,0, 2'b01,1,16'h0A01, 1,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,16'h0A01,1,16'h0B01,1, 1,8'h11,0,8'h00,1,1, 2'b01,0,16'h0A01, 1,0,1,0,0,0,1));
    tbl.push_back(mk(0,0,16'h0A01,1,16'h0B01,0, 0,8'h00,1,8'h02,1,1, 2'b01,0,16'h0A01, 0,0,0,0,1,0,1));
    tbl.push_back(mk(0,0,16'h0000,1,16'h0B01,1, 0,8'h00,0,8'h00,0,0, 2'b00,0,16'h0000, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,16'h0000,1,16'h0B01,1, 0,8'h00,0,8'h00,0,0, 2'b10,1,16'h0B01, 0,1,0,0,0,0,0));
    tbl.push_back(mk(0,0,16'h0000,1,16'h0B02,1, 0,8'h00,0,8'h00,0,0, 2'b10,1,16'h0B02, 0,1,0,0,0,0,0));
    // Isolation: s0 pushes DEAD while s1 owns; SDI 55 goes to s1 only.
    tbl.push_back(mk(0,1,16'hDEAD,0,16'h0B02,1, 1,8'h55,0,8'h00,1,1, 2'b10,0,16'h0B02, 0,1,0,1,0,0,1));
    tbl.push_back(mk(0,1,16'hDEAD,0,16'h0B02,1, 0,8'h00,1,8'h03,1,1, 2'b10,0,16'h0B02, 0,1,0,0,0,1,1));
    tbl.push_back(mk(0,1,16'hDEAD,0,16'h0000,1, 0,8'h00,0,8'h00,0,0, 2'b00,0,16'h0000, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,1,16'hDEAD,0,16'h0000,0, 0,8'h00,0,8'h00,0,0, 2'b01,1,16'hDEAD, 0,0,0,0,0,0,0));
    // Sync backpressure for 5 cycles holds the grant.
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0,0,16'hDEAD,0,16'h0000,0, 0,8'h00,1,8'h04,0,0, 2'b01,0,16'hDEAD, 0,0,0,0,1,0,0));
    tbl.push_back(mk(0,0,16'hDEAD,0,16'h0000,0, 0,8'h00,1,8'h04,1,0, 2'b01,0,16'hDEAD, 0,0,0,0,1,0,1));
    tbl.push_back(mk(0,0,16'hDEAD,0,16'h0000,0, 0,8'h00,1,8'h04,0,0, 2'b00,0,16'h0000, 0,0,0,0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge spi_clk);
      apply(tbl[i]);
      #2;
      got  = {4'h0, grant, busy, m_cmd_valid, s0_cmd_ready, s1_cmd_ready,
              s0_sdi_valid, s1_sdi_valid, s0_sync_valid, s1_sync_valid,
              m_sync_ready, m_sdi_ready, m_cmd_data};
      expv = {4'h0, tbl[i].g, |tbl[i].g, tbl[i].mcv, tbl[i].c0r, tbl[i].c1r,
              tbl[i].i0v, tbl[i].i1v, tbl[i].y0v, tbl[i].y1v,
              tbl[i].rdy, tbl[i].rdy, tbl[i].mcd};
      if (tbl[i].g == 2'b00) begin
        got[15:0]  = 16'h0;
        expv[15:0] = 16'h0;
      end
      chk($sformatf("row%0d", i), got, expv);
    end

    // SDO forwarding and return data for an s0 transaction.
    @(negedge spi_clk);
    spi_reset = 0; m_sync_valid = 0; s0_sync_ready = 0; s0_sdi_ready = 0;
    s0_cmd_valid = 1; s0_cmd_data = 16'h1001; m_cmd_ready = 1;
    s0_sdo_valid = 1; s1_sdo_valid = 1; m_sdo_ready = 1;
    #2;
    chk("sdo_idle_valid", {31'h0, m_sdo_valid}, 32'h0);
    chk("sdo_idle_ready", {30'h0, s0_sdo_ready, s1_sdo_ready}, 32'h0);
    @(negedge spi_clk); #2;
    chk("sdo_grant", {30'h0, grant}, 32'h1);
    chk("sdo_fwd", {23'h0, m_sdo_valid, m_sdo_data}, {23'h0, 1'b1, 8'hA5});
    chk("sdo_ready", {30'h0, s0_sdo_ready, s1_sdo_ready}, 32'h2);
    @(negedge spi_clk);
    s0_cmd_valid = 0; s0_sdo_valid = 0; s1_sdo_valid = 0;
    m_sdi_valid = 1; m_sdi_data = 8'h3C; s0_sdi_ready = 1;
    #2;
    chk("sdi_data", {23'h0, s0_sdi_valid, s0_sdi_data}, {23'h0, 1'b1, 8'h3C});
    chk("sdi_mready", {31'h0, m_sdi_ready}, 32'h1);
    @(negedge spi_clk);
    m_sdi_valid = 0; m_sync_valid = 1; m_sync_data = 8'h07; s0_sync_ready = 1;
    #2;
    chk("sync_data", {23'h0, s0_sync_valid, s0_sync_data}, {23'h0, 1'b1, 8'h07});
    @(negedge spi_clk);
    m_sync_valid = 0;
    #2;
    chk("sync_release", {29'h0, busy, grant}, 32'h0);

    // Both sources request continuously for three rounds.
`ifdef SPI_ENGINE_ARBITER_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`endif
    @(negedge spi_clk);
    spi_reset = 1;
    @(negedge spi_clk);
    spi_reset = 0;
    s0_cmd_valid = 1; s1_cmd_valid = 1; m_cmd_ready = 0;
    s0_sync_ready = 1; s1_sync_ready = 1; m_sync_data = 8'h0F;
    #2;
    chk("arb_start_idle", {30'h0, grant}, 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge spi_clk); #2;
      chk($sformatf("arb_grant%0d", k), {30'h0, grant}, {30'h0, exp_g[k]});
      m_sync_valid = 1;
      @(negedge spi_clk);
      m_sync_valid = 0;
      #2;
      chk($sformatf("arb_bubble%0d", k), {30'h0, grant}, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
